// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential 5-digit BCD to 16-bit binary converter (reverse double-dabble).
// One shift/correct iteration per clock; 17 iterations per conversion, so a
// result appears 17 cycles after the start is accepted.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request a conversion; only sampled while idle
//   bcd_in   in  20   packed BCD, digit 4 in [19:16] ... digit 0 in [3:0]
//   bin_out  out 16   converted value, held until the next completion
//   done     out  1   one-cycle pulse when bin_out/ovf/invalid update
//   busy     out  1   conversion in progress
//   ovf      out  1   last value exceeded 65535 (bin_out saturated)
//   invalid  out  1   last input had a digit > 9 (bin_out forced to 0)
// ---------------------------------------------------------------------------
module bcd_to_bin_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [19:0] bcd_in,
    output logic [15:0] bin_out,
    output logic        done,
    output logic        busy,
    output logic        ovf,
    output logic        invalid
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int unsigned NDIG     = 5;
    localparam int unsigned BIN_W    = 17;   // one spare bit to catch > 65535
    localparam int unsigned WORK_W   = 4 * NDIG + BIN_W;
    localparam logic [4:0]  LAST_IT  = 5'd16;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic                inv_q, inv_d;       // invalid flag of the input in flight
    logic [15:0]         bin_out_q, bin_out_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                invalid_q, invalid_d;

    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   corrected;
    logic                in_invalid;

    // Any nibble of the incoming word above 9 makes the whole input invalid.
    function automatic logic has_bad_digit(input logic [19:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign in_invalid = has_bad_digit(bcd_in);

    // One reverse double-dabble step: shift the whole word right, then pull
    // each BCD nibble that now holds a shifted-in half-ten back by 3.
    // Correction is mod-16 per nibble; no borrow crosses nibble boundaries.
    always_comb begin
        shifted   = {1'b0, work_q[WORK_W-1:1]};
        corrected = shifted;
        for (int i = 0; i < NDIG; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
                corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        inv_d     = inv_q;
        bin_out_d = bin_out_q;
        ovf_d     = ovf_q;
        invalid_d = invalid_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = 5'd0;
                    inv_d   = in_invalid;
                    state_d = CONV;
                end
            end
            CONV: begin
                work_d = corrected;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST_IT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    // Invalid input still runs the full latency; its result
                    // is discarded here.
                    if (inv_q) begin
                        bin_out_d = 16'h0000;
                        invalid_d = 1'b1;
                        ovf_d     = 1'b0;
                    end else if (corrected[BIN_W-1]) begin
                        bin_out_d = 16'hFFFF;
                        invalid_d = 1'b0;
                        ovf_d     = 1'b1;
                    end else begin
                        bin_out_d = corrected[15:0];
                        invalid_d = 1'b0;
                        ovf_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            work_q    <= '0;
            inv_q     <= 1'b0;
            bin_out_q <= 16'h0000;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            inv_q     <= inv_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            invalid_q <= invalid_d;
        end
    end

    assign bin_out = bin_out_q;
    assign done    = done_q;
    assign busy    = (state_q == CONV);
    assign ovf     = ovf_q;
    assign invalid = invalid_q;

endmodule
